sign_apply_pipe: RTL and testbench



---
 rtl/sign_apply_pipe.sv | 92 +++++++++
 tb/tb_sign_apply_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sign_apply_pipe.sv
// sign_apply_pipe: sign-magnitude to two's-complement restore, 2-stage valid/ready.
// Define SIGN_APPLY_SAT_EN to clamp overflowed results; otherwise they wrap.
module sign_apply_pipe #(
  parameter int BW_IN  = 32,
  parameter int BW_OUT = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BW_IN-1:0]  in_mag,
  input  logic              in_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW_OUT-1:0] out,
  output logic [CNT_W-1:0]  ovf_cnt,
  input  logic              clr_cnt
);

  // Working width holds the exact value plus one guard bit for the range test.
  localparam int WV = ((BW_IN + 1 > BW_OUT) ? BW_IN + 1 : BW_OUT) + 1;
  localparam int WT = WV - BW_OUT + 1;

  logic              s1_valid;
  logic [BW_IN-1:0]  s1_mag;
  logic              s1_neg;
  logic              s1_load;
  logic              s2_load;
  logic [WV-1:0]     mag_ext;
  logic [WV-1:0]     v;
  logic [WT-1:0]     v_top;
  logic              ovf;
  logic [BW_OUT-1:0] res;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Exact signed value; it fits when the bits above the output sign all agree.
  always_comb begin
    mag_ext = WV'(s1_mag);
    v       = s1_neg ? (~mag_ext + 1'b1) : mag_ext;
    v_top   = v[WV-1:BW_OUT-1];
    ovf     = !((&v_top) || !(|v_top));
    res     = v[BW_OUT-1:0];
`ifdef SIGN_APPLY_SAT_EN
    if (ovf) begin
      res = s1_neg ? {1'b1, {(BW_OUT-1){1'b0}}}
                   : {1'b0, {(BW_OUT-1){1'b1}}};
    end
`endif
  end

  // Stage 1 captures the raw magnitude and sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
      s1_neg   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mag <= in_mag;
        s1_neg <= in_neg;
      end
    end
  end

  // Stage 2 holds the finished result until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) out <= res;
    end
  end

  // Overflow counter bumps as the beat enters stage 2; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= '0;
    end else if (s2_load && s1_valid && ovf && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sign_apply_pipe.sv
// tb_sign_apply_pipe: directed vectors for sign_apply_pipe.
// Three instances: 8->8, 8->12, and 8->8 with a 2-bit counter.
module tb_sign_apply_pipe;

`ifdef SIGN_APPLY_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_mag;
  logic        in_neg;
  logic        out_ready;
  logic        clr_cnt;
  logic        clr_c;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [7:0]  out_a;
  logic [11:0] out_b;
  logic [7:0]  out_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int checks;
  int errors;

  sign_apply_pipe #(.BW_IN(8), .BW_OUT(8), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_mag(in_mag), .in_neg(in_neg),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out(out_a), .ovf_cnt(cnt_a), .clr_cnt(clr_cnt)
  );

  sign_apply_pipe #(.BW_IN(8), .BW_OUT(12), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_mag(in_mag), .in_neg(in_neg),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out(out_b), .ovf_cnt(cnt_b), .clr_cnt(clr_cnt)
  );

  sign_apply_pipe #(.BW_IN(8), .BW_OUT(8), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_c),
    .in_mag(in_mag), .in_neg(in_neg),
    .out_valid(out_valid_c), .out_ready(out_ready),
    .out(out_c), .ovf_cnt(cnt_c), .clr_cnt(clr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mag;
    logic        neg;
    logic [7:0]  ea;
    logic [11:0] eb;
    int          ec;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mag    = '0;
    in_neg    = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    clr_c     = 1'b0;

    vt[0] = '{8'd5,   1'b1, 8'hFB, 12'hFFB, 0};
    vt[1] = '{8'd128, 1'b1, 8'h80, 12'hF80, 0};
    vt[2] = '{8'd128, 1'b0, SAT ? 8'h7F : 8'h80, 12'h080, 1};
    vt[3] = '{8'd255, 1'b1, SAT ? 8'h80 : 8'h01, 12'hF01, 2};
    vt[4] = '{8'd0,   1'b1, 8'h00, 12'h000, 2};
    vt[5] = '{8'd127, 1'b0, 8'h7F, 12'h07F, 2};
    vt[6] = '{8'd200, 1'b0, SAT ? 8'h7F : 8'hC8, 12'h0C8, 3};
    vt[7] = '{8'd129, 1'b1, SAT ? 8'h80 : 8'h7F, 12'hF7F, 4};
    vt[8] = '{8'd0,   1'b0, 8'h00, 12'h000, 4};

    // reset state
    #12;
    chk("rst_out_valid", {29'd0, out_valid_a, out_valid_b, out_valid_c}, 0);
    chk("rst_out", {12'd0, out_a, out_b}, 0);
    chk("rst_cnt", {14'd0, cnt_a, cnt_c}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {29'd0, in_ready_a, in_ready_b, in_ready_c}, 3'b111);

    // vector table, one beat in flight at a time
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_mag   = vt[i].mag;
      in_neg   = vt[i].neg;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready_a}, 1);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_lat1", i), {31'd0, out_valid_a}, 0);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid_a}, 1);
      chk($sformatf("v%0d_valid_bc", i),
          {30'd0, out_valid_b, out_valid_c}, 2'b11);
      chk($sformatf("v%0d_out_a", i), {24'd0, out_a}, {24'd0, vt[i].ea});
      chk($sformatf("v%0d_out_b", i), {20'd0, out_b}, {20'd0, vt[i].eb});
      chk($sformatf("v%0d_out_c", i), {24'd0, out_c}, {24'd0, vt[i].ea});
      chk($sformatf("v%0d_cnt_a", i), {16'd0, cnt_a}, vt[i].ec);
      chk($sformatf("v%0d_cnt_b", i), {16'd0, cnt_b}, 0);
      chk($sformatf("v%0d_cnt_c", i), {30'd0, cnt_c},
          (vt[i].ec > 3) ? 3 : vt[i].ec);
    end
    step();
    chk("drain_valid", {31'd0, out_valid_a}, 0);

    // backpressure: three beats against a stalled sink
    out_ready = 1'b0;
    in_neg    = 1'b0;
    in_valid  = 1'b1;
    in_mag    = 8'h01;
    step();
    in_mag = 8'h02;
    chk("bp_ready1", {31'd0, in_ready_a}, 1);
    step();
    in_mag = 8'h03;
    chk("bp_ready2", {31'd0, in_ready_a}, 0);
    chk("bp_ready2_c", {31'd0, in_ready_c}, 0);
    chk("bp_hold0", {23'd0, out_valid_a, out_a}, {23'd0, 1'b1, 8'h01});
    step();
    step();
    chk("bp_hold1", {23'd0, out_valid_a, out_a}, {23'd0, 1'b1, 8'h01});
    chk("bp_ready3", {31'd0, in_ready_a}, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready_a}, 1);
    step();
    in_valid = 1'b0;
    chk("bp_out2", {23'd0, out_valid_a, out_a}, {23'd0, 1'b1, 8'h02});
    step();
    chk("bp_out3", {23'd0, out_valid_a, out_a}, {23'd0, 1'b1, 8'h03});
    step();
    chk("bp_empty", {31'd0, out_valid_a}, 0);

    // counter clear races a fourth overflow
    clr_cnt = 1'b1;
    step();
    clr_cnt  = 1'b0;
    in_valid = 1'b1;
    in_mag   = 8'd128;
    in_neg   = 1'b0;
    for (int k = 0; k < 4; k++) step();
    in_valid = 1'b0;
    chk("clr_pre", {16'd0, cnt_a}, 3);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_wins", {16'd0, cnt_a}, 0);
    step();
    chk("clr_after", {16'd0, cnt_a}, 0);
    chk("sat_cnt_c", {30'd0, cnt_c}, 3);

    // reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mag    = 8'd128;
    step();
    step();
    in_valid = 1'b0;
    chk("rst2_full", {30'd0, out_valid_a, in_ready_a}, 2'b10);
    chk("rst2_cnt", {16'd0, cnt_a}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", {31'd0, out_valid_a}, 0);
    chk("rst2_out", {24'd0, out_a}, 0);
    chk("rst2_cnt0", {16'd0, cnt_a}, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("rst2_ready", {31'd0, in_ready_a}, 1);
    chk("rst2_stale1", {31'd0, out_valid_a}, 0);
    step();
    chk("rst2_stale2", {31'd0, out_valid_a}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
